// File: rtl/jpeg_idct_transpose_ctrl_if.sv
// ----------------------------------------------------------------------------
// jpeg_idct_transpose_ctrl_if
//   Streaming bus between the IDCT column pass, the transpose controller and
//   the IDCT row pass. Signal suffixes are relative to the controller.
//
//   in_valid_i   pass-1 word valid
//   in_data_i    pass-1 word (32b)
//   in_ready_o   controller can accept the pass-1 word
//   out_valid_o  transposed word valid
//   out_data_o   transposed word (32b)
//   out_last_o   last word of a bank
//   out_ready_i  downstream accepts the transposed word
//
//   slave  : controller side
//   master : environment side (column pass source + row pass sink)
// ----------------------------------------------------------------------------
interface jpeg_idct_transpose_ctrl_if;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        out_ready_i;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/jpeg_idct_transpose_ctrl.sv
// ----------------------------------------------------------------------------
// jpeg_idct_transpose_ctrl
//   Ping-pong sequencer for a 32x32b dual-port read-first transpose RAM.
//   The RAM is split into two banks of ROWS*COLS words. Port 0 writes the
//   pass-1 stream row-major into one bank while port 1 reads the other bank
//   column-major into the pass-2 stream through a 3-entry output FIFO.
//
//   Optional feature macro: JPEG_IDCT_TPOSE_ABORT_EN
//     defined   -> adds abort_i (sync) which empties both banks, zeroes the
//                  pointers and indices, flushes the FIFO and drops the
//                  in-flight read.
//     undefined -> no abort_i port; only rst_i clears state.
//
//   Ports
//     clk_i        clock
//     rst_i        asynchronous reset, active low
//     abort_i      synchronous abort (JPEG_IDCT_TPOSE_ABORT_EN only)
//     strm         streaming bus (slave modport): pass-1 in, pass-2 out
//     ram_addr0_o  RAM port 0 address {wr_bank, row*COLS+col}
//     ram_data0_o  RAM port 0 write data (pass-through of in_data_i)
//     ram_wr0_o    RAM port 0 write enable
//     ram_addr1_o  RAM port 1 address {rd_bank, row*COLS+col}
//     ram_data1_i  RAM port 1 read data, one cycle after the address
//     bank_full_o  per-bank FULL/DRAINING status
//
//   Bank state table
//     state          | meaning
//     BANK_EMPTY     | free, writer may start on it
//     BANK_FILLING   | writer has stored at least one word
//     BANK_FULL      | all words written, no read issued yet
//     BANK_DRAINING  | reader has issued at least one read
// ----------------------------------------------------------------------------
module jpeg_idct_transpose_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
`ifdef JPEG_IDCT_TPOSE_ABORT_EN
    input  logic                       abort_i,
`endif
    jpeg_idct_transpose_ctrl_if.slave  strm,
    output logic [4:0]                 ram_addr0_o,
    output logic [31:0]                ram_data0_o,
    output logic                       ram_wr0_o,
    output logic [4:0]                 ram_addr1_o,
    input  logic [31:0]                ram_data1_i,
    output logic [1:0]                 bank_full_o
);

    localparam int            NW       = ROWS * COLS;
    localparam int            IW       = $clog2(NW);
    localparam int            RB       = $clog2(ROWS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_st_e;

    bank_st_e      bank_st_q [2];
    logic          wr_bank_q;
    logic          rd_bank_q;
    logic [IW-1:0] wr_idx_q;
    logic [IW-1:0] rd_idx_q;
    logic          init_q;

    logic          inflight_q;
    logic          inflight_last_q;
    logic [31:0]   fifo_data_q [3];
    logic          fifo_last_q [3];
    logic [1:0]    fifo_wp_q;
    logic [1:0]    fifo_rp_q;
    logic [1:0]    fifo_cnt_q;
    logic [1:0]    fifo_cnt_d;

    logic          abort;
    bank_st_e      wr_st;
    bank_st_e      rd_st;
    logic          wr_open;
    logic          wr_fire;
    logic          wr_last;
    logic          rd_fire;
    logic          rd_last;
    logic [2:0]    credits;
    logic          fifo_push;
    logic          fifo_pop;
    logic [IW-1:0] rd_addr_idx;

`ifdef JPEG_IDCT_TPOSE_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign wr_st   = bank_st_q[wr_bank_q];
    assign rd_st   = bank_st_q[rd_bank_q];
    assign wr_open = (wr_st == BANK_EMPTY) || (wr_st == BANK_FILLING);

    // init_q keeps in_ready_o low until the first edge after reset release.
    assign strm.in_ready_o = init_q & wr_open & ~abort;
    assign wr_fire         = strm.in_valid_i & strm.in_ready_o;
    assign wr_last         = (wr_idx_q == IDX_LAST);

    // Credits cover FIFO occupancy plus the read whose data is still in the RAM.
    assign credits = 3'(fifo_cnt_q) + 3'(inflight_q);
    assign rd_fire = ((rd_st == BANK_FULL) || (rd_st == BANK_DRAINING)) &&
                     (credits < 3'd3) && !abort;
    assign rd_last = (rd_idx_q == IDX_LAST);

    // rd_idx counts with the row in the low bits, so {row, col} walks column-major.
    assign rd_addr_idx = {rd_idx_q[RB-1:0], rd_idx_q[IW-1:RB]};

    assign ram_addr0_o = 5'({wr_bank_q, wr_idx_q});
    assign ram_data0_o = strm.in_data_i;
    assign ram_wr0_o   = wr_fire;
    assign ram_addr1_o = 5'({rd_bank_q, rd_addr_idx});

    assign bank_full_o[0] = (bank_st_q[0] == BANK_FULL) || (bank_st_q[0] == BANK_DRAINING);
    assign bank_full_o[1] = (bank_st_q[1] == BANK_FULL) || (bank_st_q[1] == BANK_DRAINING);

    assign strm.out_valid_o = (fifo_cnt_q != 2'd0) & ~abort;
    assign strm.out_data_o  = fifo_data_q[fifo_rp_q];
    assign strm.out_last_o  = fifo_last_q[fifo_rp_q];

    assign fifo_push = inflight_q;
    assign fifo_pop  = strm.out_valid_o & strm.out_ready_i;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Bank sequencing. Writer and reader touch the same bank only while it is
    // EMPTY/FILLING (reader idle) or FULL/DRAINING (writer idle), so the two
    // updates below never land on the same element in one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            init_q       <= 1'b0;
        end else if (abort) begin
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            init_q       <= 1'b1;
        end else begin
            init_q <= 1'b1;
            if (wr_fire) begin
                if (wr_last) begin
                    bank_st_q[wr_bank_q] <= BANK_FULL;
                    wr_bank_q            <= ~wr_bank_q;
                    wr_idx_q             <= '0;
                end else begin
                    bank_st_q[wr_bank_q] <= BANK_FILLING;
                    wr_idx_q             <= wr_idx_q + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    bank_st_q[rd_bank_q] <= BANK_EMPTY;
                    rd_bank_q            <= ~rd_bank_q;
                    rd_idx_q             <= '0;
                end else begin
                    bank_st_q[rd_bank_q] <= BANK_DRAINING;
                    rd_idx_q             <= rd_idx_q + 1'b1;
                end
            end
        end
    end

    // Read pipeline: issue, RAM data one cycle later, then into the FIFO.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_wp_q       <= 2'd0;
            fifo_rp_q       <= 2'd0;
            fifo_cnt_q      <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else if (abort) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_wp_q       <= 2'd0;
            fifo_rp_q       <= 2'd0;
            fifo_cnt_q      <= 2'd0;
        end else begin
            inflight_q      <= rd_fire;
            inflight_last_q <= rd_fire & rd_last;
            if (fifo_push) begin
                fifo_data_q[fifo_wp_q] <= ram_data1_i;
                fifo_last_q[fifo_wp_q] <= inflight_last_q;
                fifo_wp_q              <= ptr_inc(fifo_wp_q);
            end
            if (fifo_pop) begin
                fifo_rp_q <= ptr_inc(fifo_rp_q);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
`timescale 1ns/1ps
module tb_jpeg_idct_transpose_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NW   = ROWS * COLS;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    jpeg_idct_transpose_ctrl_if strm();

    logic [4:0]  ram_addr0_o;
    logic [31:0] ram_data0_o;
    logic        ram_wr0_o;
    logic [4:0]  ram_addr1_o;
    logic [31:0] ram_data1_i;
    logic [1:0]  bank_full_o;
`ifdef JPEG_IDCT_TPOSE_ABORT_EN
    logic        abort_i = 1'b0;
`endif

    jpeg_idct_transpose_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
`ifdef JPEG_IDCT_TPOSE_ABORT_EN
        .abort_i     (abort_i),
`endif
        .strm        (strm),
        .ram_addr0_o (ram_addr0_o),
        .ram_data0_o (ram_data0_o),
        .ram_wr0_o   (ram_wr0_o),
        .ram_addr1_o (ram_addr1_o),
        .ram_data1_i (ram_data1_i),
        .bank_full_o (bank_full_o)
    );

    // Read-first dual-port RAM model.
    logic [31:0] mem [32];
    always @(posedge clk_i) begin
        if (ram_wr0_o) mem[ram_addr0_o] <= ram_data0_o;
        ram_data1_i <= mem[ram_addr1_o];
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] sb [$];
    logic [31:0] bank_buf [NW];
    int          bank_cnt = 0;
    logic        tb_wr_bank = 1'b0;
    logic [31:0] src_word = '0;
    bit          rand_data = 1'b0;
    int          to_send = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          stall_cnt = 0;
    int          first_valid_cyc = -1;
    int          first_out_cyc = -1;
    int          last_out_cyc = -1;
    int          last_wr_edge = 0;
    int          base_acc;
    int          base_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, evaluate handshakes 1ns later (well before posedge).
    task automatic step(input bit v, input bit r);
        @(negedge clk_i);
        strm.in_valid_i  = v && (to_send > 0);
        strm.in_data_i   = src_word;
        strm.out_ready_i = r;
`ifdef JPEG_IDCT_TPOSE_ABORT_EN
        abort_i = 1'b0;
`endif
        #1;
        if (strm.in_valid_i && !strm.in_ready_o) stall_cnt++;
        if (strm.out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (strm.in_valid_i && strm.in_ready_o) begin
            chk("wr_addr", 64'(ram_addr0_o), 64'({tb_wr_bank, 4'(bank_cnt)}));
            bank_buf[bank_cnt] = src_word;
            bank_cnt++;
            n_acc++;
            to_send--;
            last_wr_edge = cyc + 1;
            if (bank_cnt == NW) begin
                for (int c = 0; c < COLS; c++)
                    for (int rr = 0; rr < ROWS; rr++)
                        sb.push_back({(c == COLS-1) && (rr == ROWS-1), bank_buf[rr*COLS + c]});
                bank_cnt   = 0;
                tb_wr_bank = ~tb_wr_bank;
            end
            src_word = rand_data ? $urandom : src_word + 32'd1;
        end
        if (strm.out_valid_o && strm.out_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 64'(sb.size()), 64'(1));
            end else begin
                logic [32:0] exp_w;
                exp_w = sb.pop_front();
                chk("out_word", 64'({strm.out_last_o, strm.out_data_o}), 64'(exp_w));
            end
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
    endtask

    task automatic run_words(input int n, input int vpct, input int rpct, input int budget,
                             input string tag);
        int k;
        to_send += n;
        k = 0;
        while ((to_send > 0 || sb.size() > 0) && k < budget) begin
            step(int'($urandom_range(99)) < vpct, int'($urandom_range(99)) < rpct);
            k++;
        end
        chk({tag, "_done"}, 64'(to_send + sb.size()), 64'(0));
    endtask

    task automatic clear_model();
        sb.delete();
        bank_cnt   = 0;
        tb_wr_bank = 1'b0;
        to_send    = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_i);
        rst_i            = 1'b0;
        strm.in_valid_i  = 1'b1;
        strm.in_data_i   = '0;
        strm.out_ready_i = 1'b1;
        #1;
        chk({tag, "_rdy"},   64'(strm.in_ready_o),  64'(0));
        chk({tag, "_ovld"},  64'(strm.out_valid_o), 64'(0));
        chk({tag, "_olast"}, 64'(strm.out_last_o),  64'(0));
        chk({tag, "_odata"}, 64'(strm.out_data_o),  64'(0));
        chk({tag, "_wr0"},   64'(ram_wr0_o),        64'(0));
        chk({tag, "_addr1"}, 64'(ram_addr1_o),      64'(0));
        chk({tag, "_bfull"}, 64'(bank_full_o),      64'(0));
        repeat (2) @(negedge clk_i);
        rst_i           = 1'b1;
        strm.in_valid_i = 1'b0;
        clear_model();
        step(1'b0, 1'b1);
        chk({tag, "_rdy1"}, 64'(strm.in_ready_o),  64'(1));
        chk({tag, "_ovl1"}, 64'(strm.out_valid_o), 64'(0));
    endtask

    // Fill bank 0 and seven words of bank 1 while bank 0 drains.
    task automatic fill_23();
        int k;
        rand_data = 1'b0;
        src_word  = 32'h200;
        to_send   = NW + 7;
        k = 0;
        while (to_send > 0 && k < 100) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("mid_sent", 64'(to_send), 64'(0));
        chk("mid_bfull", 64'(bank_full_o), 64'(2'b01));
    endtask

    initial begin
        strm.in_valid_i  = 1'b0;
        strm.in_data_i   = '0;
        strm.out_ready_i = 1'b0;

        do_reset("rst");

        // Single bank: transposed order, last only on the final word, latency N+2.
        rand_data       = 1'b0;
        src_word        = 32'd0;
        first_valid_cyc = -1;
        run_words(NW, 100, 100, 100, "t2");
        chk("t2_lat", 64'(first_valid_cyc), 64'(last_wr_edge + 2));
        chk("t2_idle", 64'(bank_full_o), 64'(0));

        // Continuous 4 banks with out_ready held high.
        src_word      = 32'h1000;
        stall_cnt     = 0;
        first_out_cyc = -1;
        base_out      = n_out;
        run_words(4*NW, 100, 100, 200, "t3");
        chk("t3_stall", 64'(stall_cnt), 64'(0));
        chk("t3_cnt", 64'(n_out - base_out), 64'(4*NW));
        chk("t3_rate", 64'(last_out_cyc - first_out_cyc), 64'(4*NW - 1));

        // Backpressure: only two banks fit, then release.
        src_word = 32'h2000;
        base_acc = n_acc;
        base_out = n_out;
        to_send  = 48;
        repeat (60) step(1'b1, 1'b0);
        chk("t4_acc", 64'(n_acc - base_acc), 64'(2*NW));
        chk("t4_rdy", 64'(strm.in_ready_o), 64'(0));
        chk("t4_bfull", 64'(bank_full_o), 64'(2'b11));
        run_words(0, 100, 100, 300, "t4");
        chk("t4_out", 64'(n_out - base_out), 64'(48));
        chk("t4_acc2", 64'(n_acc - base_acc), 64'(48));

        // Random valid/ready over 1000 banks of random data.
        rand_data = 1'b1;
        src_word  = $urandom;
        run_words(1000*NW, 75, 50, 60000, "t5");
        chk("t5_idle", 64'(bank_full_o), 64'(0));

`ifdef JPEG_IDCT_TPOSE_ABORT_EN
        fill_23();
        @(negedge clk_i);
        abort_i          = 1'b1;
        strm.in_valid_i  = 1'b1;
        strm.out_ready_i = 1'b1;
        #1;
        chk("ab_rdy", 64'(strm.in_ready_o), 64'(0));
        chk("ab_ovld", 64'(strm.out_valid_o), 64'(0));
        clear_model();
        step(1'b0, 1'b1);
        chk("ab_nv", 64'(strm.out_valid_o), 64'(0));
        chk("ab_rdy1", 64'(strm.in_ready_o), 64'(1));
        chk("ab_bfull", 64'(bank_full_o), 64'(0));
        rand_data = 1'b0;
        src_word  = 32'h100;
        run_words(NW, 100, 100, 100, "ab");
`endif

        // Reset in the middle of operation, then a clean bank.
        fill_23();
        do_reset("mr");
        chk("mr_bfull", 64'(bank_full_o), 64'(0));
        rand_data = 1'b0;
        src_word  = 32'h100;
        run_words(NW, 100, 100, 100, "mr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
